clk_gen_sequencer: RTL and testbench

//  Sequences a programmable, synthesizable test clock from a fast reference clock.

---
 rtl/clk_gen_seq_pkg.sv | 14 +
 rtl/clk_gen_phase_cnt.sv | 29 ++
 rtl/clk_gen_sequencer.sv | 134 +++++++++++++
 tb/tb_clk_gen_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/clk_gen_seq_pkg.sv
// Shared types and default widths for the clock-burst sequencer.
//   clk_seq_state_t : FSM states (IDLE, HIGH, LOW)
//   DIV_W_DEF       : default half-period counter width
//   BURST_W_DEF     : default burst-length width
package clk_gen_seq_pkg;
  localparam int DIV_W_DEF   = 16;
  localparam int BURST_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } clk_seq_state_t;
endpackage

// File: rtl/clk_gen_phase_cnt.sv
// Loadable phase counter: counts reference cycles spent in the current
// clk_out phase.
//   i_clk, i_resetn : reference clock, synchronous active-low reset
//   i_load          : restart the phase (counter <= 1)
//   i_en            : advance the counter by one
//   i_len           : phase length in reference cycles
//   o_last          : counter has reached i_len (final cycle of the phase)
module clk_gen_phase_cnt #(
  parameter int DIV_W = clk_gen_seq_pkg::DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_len,
  output logic             o_last
);
  logic [DIV_W-1:0] r_cnt;

  // The first cycle of a phase is already count 1, so the count never needs
  // to pass i_len and cannot wrap even when i_len is all ones.
  always_ff @(posedge i_clk) begin
    if (!i_resetn)   r_cnt <= '0;
    else if (i_load) r_cnt <= {{(DIV_W-1){1'b0}}, 1'b1};
    else if (i_en)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_last = (r_cnt == i_len);
endmodule

// File: rtl/clk_gen_sequencer.sv
// Programmable clock-burst sequencer. On an accepted start it latches a
// half-period and burst length, then emits a 50% duty divided clock plus
// edge strobes, stopping only at period boundaries.
//   clk, resetn        : reference clock, synchronous active-low reset
//   cfg_div, cfg_burst : half-period / period count (0 = continuous), sampled on start
//   start, stop        : single-cycle requests
//   clk_out            : generated clock (registered)
//   rise_stb/fall_stb  : high in the cycle clk_out rises / falls
//   busy, done, err    : run status, end-of-run pulse, rejected-start pulse
module clk_gen_sequencer
  import clk_gen_seq_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               rise_stb,
  output logic               fall_stb,
  output logic               busy,
  output logic               done,
  output logic               err
);
  clk_seq_state_t     r_state;
  logic [DIV_W-1:0]   r_div_q;
  logic [BURST_W-1:0] r_burst_q;
  logic [BURST_W-1:0] r_period_cnt;
  logic               r_stop_pend;
  logic               r_clk_out, r_rise, r_fall, r_busy, r_done, r_err;

  logic               w_start_ok;
  logic               w_load;
  logic               w_en;
  logic               w_last;
  logic               w_burst_end;
  logic [BURST_W-1:0] w_period_nxt;

  assign w_start_ok = (r_state == IDLE) && start && (cfg_div != '0);
  // A phase restarts either on a fresh start or on the final cycle of a phase.
  assign w_load     = (r_state == IDLE) ? w_start_ok : w_last;
  assign w_en       = (r_state != IDLE) && !w_last;

  // One bit wider so period_cnt+1 never aliases to 0 at all-ones.
  assign w_burst_end  = (r_burst_q != '0) &&
                        (({1'b0, r_period_cnt} + 1'b1) == {1'b0, r_burst_q});
  assign w_period_nxt = (&r_period_cnt) ? r_period_cnt : r_period_cnt + 1'b1;

  clk_gen_phase_cnt #(.DIV_W(DIV_W)) u_phase (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_load   (w_load),
    .i_en     (w_en),
    .i_len    (r_div_q),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_div_q      <= '0;
      r_burst_q    <= '0;
      r_period_cnt <= '0;
      r_stop_pend  <= 1'b0;
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // stop is meaningless here, including alongside start
          if (w_start_ok) begin
            r_state      <= HIGH;
            r_div_q      <= cfg_div;
            r_burst_q    <= cfg_burst;
            r_period_cnt <= '0;
            r_stop_pend  <= 1'b0;
            r_clk_out    <= 1'b1;
            r_rise       <= 1'b1;
            r_busy       <= 1'b1;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        HIGH: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_last) begin
            r_state   <= LOW;
            r_clk_out <= 1'b0;
            r_fall    <= 1'b1;
          end
        end
        LOW: begin
          if (w_last) begin
            if (r_stop_pend || w_burst_end) begin
              // Ending anyway: a stop arriving on this edge is absorbed.
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_stop_pend <= 1'b0;
            end else begin
              r_state      <= HIGH;
              r_clk_out    <= 1'b1;
              r_rise       <= 1'b1;
              r_period_cnt <= w_period_nxt;
              if (stop) r_stop_pend <= 1'b1;
            end
          end else if (stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign clk_out  = r_clk_out;
  assign rise_stb = r_rise;
  assign fall_stb = r_fall;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
endmodule

// File: tb/tb_clk_gen_sequencer.sv
module tb_clk_gen_sequencer;
  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cfg_div;
  logic [15:0] cfg_burst;
  logic        start, stop;
  logic        clk_out, rise_stb, fall_stb, busy, done, err;

  always #5 clk = ~clk;

  clk_gen_sequencer #(.DIV_W(16), .BURST_W(16)) dut (
    .clk(clk), .resetn(resetn), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
    .start(start), .stop(stop), .clk_out(clk_out), .rise_stb(rise_stb),
    .fall_stb(fall_stb), .busy(busy), .done(done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a run is described by its start edge, half-period d, burst b and
  // the period in which a stop landed. Output at display cycle n (n=1 is the
  // first cycle after the start edge) follows from position n-1 within a 2d
  // period; the run lasts P periods and done shows at n = 2dP+1.
  longint e = 0, t0 = 0, md = 0, mb = 0, pstop = 0, n, p, pos;
  bit run = 1'b0;
  bit x_clk = 0, x_rise = 0, x_fall = 0, x_busy = 0, x_done = 0, x_err = 0;

  always @(posedge clk) begin
    e++;
    {x_clk, x_rise, x_fall, x_busy, x_done, x_err} = '0;
    if (!resetn) begin
      run = 1'b0;
    end else if (run) begin
      n = e - t0 + 1;
      p = pstop;                                   // 0 means unbounded
      if (mb != 0 && (p == 0 || mb < p)) p = mb;
      if (p != 0 && n == 2*md*p + 1) begin
        x_done = 1'b1;
        run = 1'b0;
      end else begin
        if (stop && pstop == 0) pstop = (n + 2*md - 1) / (2*md);
        pos    = (n - 1) % (2*md);
        x_clk  = (pos < md);
        x_rise = (pos == 0);
        x_fall = (pos == md);
        x_busy = 1'b1;
      end
    end else if (start) begin
      if (cfg_div != 0) begin
        run = 1'b1; t0 = e; md = cfg_div; mb = cfg_burst; pstop = 0;
        x_clk = 1'b1; x_rise = 1'b1; x_busy = 1'b1;
      end else begin
        x_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("clk_out", clk_out, x_clk);
      chk("rise_stb", rise_stb, x_rise);
      chk("fall_stb", fall_stb, x_fall);
      chk("busy", busy, x_busy);
      chk("done", done, x_done);
      chk("err", err, x_err);
    end
  end

  // Observation window statistics filled by watch()
  int s_rise, s_fall, s_busy, s_done, s_dat, s_err, s_r1, s_r2;

  // Observe n display cycles; start/stop are dropped after the first edge.
  task automatic watch(input int cycles);
    s_rise = 0; s_fall = 0; s_busy = 0; s_done = 0; s_dat = 0; s_err = 0;
    s_r1 = 0; s_r2 = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk); #1;
      if (rise_stb) begin
        s_rise++;
        if (s_r1 == 0) s_r1 = i; else if (s_r2 == 0) s_r2 = i;
      end
      if (fall_stb) s_fall++;
      if (busy) s_busy++;
      if (done) begin s_done++; if (s_dat == 0) s_dat = i; end
      if (err) s_err++;
      if (i == 1) begin start = 1'b0; stop = 1'b0; end
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0; cfg_div = '0; cfg_burst = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst clk_out", clk_out, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk_en = 1'b1;
    resetn = 1'b1;
    watch(1);

    // 1: div 3, burst 4
    cfg_div = 3; cfg_burst = 4; start = 1'b1;
    watch(30);
    chk("t1 rises", s_rise, 4);
    chk("t1 falls", s_fall, 4);
    chk("t1 busy cycles", s_busy, 24);
    chk("t1 done cycle", s_dat, 25);
    chk("t1 done count", s_done, 1);
    chk("t1 first rise", s_r1, 1);
    chk("t1 rise spacing", s_r2 - s_r1, 6);

    // 3: rejected start
    cfg_div = 0; cfg_burst = 2; start = 1'b1;
    watch(5);
    chk("t3 err count", s_err, 1);
    chk("t3 busy", s_busy, 0);
    chk("t3 rises", s_rise, 0);

    // 2: div 1 continuous, stop during HIGH of period 5
    cfg_div = 1; cfg_burst = 0; start = 1'b1;
    watch(9);
    chk("t2 rises before stop", s_rise, 5);
    stop = 1'b1;
    watch(6);
    chk("t2 rises after stop", s_rise, 0);
    chk("t2 done cycle", s_dat, 2);
    chk("t2 done count", s_done, 1);

    // 4: start while busy with new cfg is ignored
    cfg_div = 2; cfg_burst = 0; start = 1'b1;
    watch(5);
    cfg_div = 7; start = 1'b1;
    watch(8);
    chk("t4 period", s_r2 - s_r1, 4);
    chk("t4 err", s_err, 0);
    stop = 1'b1;
    watch(6);
    chk("t4 done cycle", s_dat, 4);

    // 5: reset during HIGH, then restart
    cfg_div = 5; cfg_burst = 0; start = 1'b1;
    watch(3);
    resetn = 1'b0;
    watch(1);
    chk("t5 clk_out", clk_out, 0);
    chk("t5 busy", busy, 0);
    chk("t5 done", s_done, 0);
    resetn = 1'b1;
    cfg_div = 2; cfg_burst = 1; start = 1'b1;
    watch(8);
    chk("t5 restart rises", s_rise, 1);
    chk("t5 restart done", s_dat, 5);

    // 6: stop in final LOW cycle of burst, then immediate restart
    cfg_div = 2; cfg_burst = 2; start = 1'b1;
    watch(8);
    chk("t6 rises", s_rise, 2);
    chk("t6 no early done", s_done, 0);
    stop = 1'b1;
    watch(1);
    chk("t6 done", s_done, 1);
    cfg_div = 1; cfg_burst = 1; start = 1'b1;
    watch(4);
    chk("t6 restart rise", s_r1, 1);
    chk("t6 restart done", s_dat, 3);
    chk("t6 restart done count", s_done, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
